fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: one read per cycle into a 2-entry {instr, pc} buffer; request T -> out_valid T+2.
// Backpressure: requests stop once buffered plus in-flight words would exceed two; redirect flushes.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_request,
  output logic        mem_we_re,
  output logic [3:0]  mem_mask,
  output logic [7:0]  mem_address,
  output logic [31:0] mem_data_in,
  input  logic        mem_valid,
  input  logic [31:0] mem_data_out,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  logic [1:0]  r_count;
  logic [31:0] r_fetch_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic [31:0] r_instr0, r_instr1;
  logic [31:0] r_pc0, r_pc1;

  logic        w_pop;
  logic        w_write;
  logic [2:0]  w_occupancy;
  logic [1:0]  w_write_idx;
  logic [31:0] w_redirect_pc;

  assign out_valid   = (r_count != 2'd0);
  assign out_instr   = r_instr0;
  assign out_pc      = r_pc0;

  assign mem_we_re   = 1'b0;
  assign mem_mask    = 4'b1111;
  assign mem_data_in = 32'h0;
  assign mem_address = r_fetch_pc[9:2];

  assign w_pop         = out_valid & out_ready;
  assign w_write       = mem_valid & r_inflight & ~redirect;
  assign w_write_idx   = r_count - {1'b0, w_pop};
  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

  // Words already buffered (after this cycle's pop) plus the one still in flight.
  assign w_occupancy = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_inflight};
  assign mem_request = ~rst & ~redirect & (w_occupancy < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count       <= 2'd0;
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0;
      r_instr0      <= 32'h0;
      r_instr1      <= 32'h0;
      r_pc0         <= 32'h0;
      r_pc1         <= 32'h0;
    end else if (redirect) begin
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
      r_fetch_pc <= w_redirect_pc;
    end else begin
      r_count <= r_count + {1'b0, w_write} - {1'b0, w_pop};
      // Head is always entry 0; a pop shifts entry 1 forward before the tail write lands.
      if (w_pop) begin
        r_instr0 <= r_instr1;
        r_pc0    <= r_pc1;
      end
      if (w_write) begin
        if (w_write_idx == 2'd0) begin
          r_instr0 <= mem_data_out;
          r_pc0    <= r_inflight_pc;
        end else begin
          r_instr1 <= mem_data_out;
          r_pc1    <= r_inflight_pc;
        end
      end
      if (mem_request) begin
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 32'd4;
      end else if (mem_valid) begin
        r_inflight <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a queue-based model of the instruction stream
// plus a memory that answers each request one cycle later with word k = 32'h1000_0000 + k.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_request;
  logic        mem_we_re;
  logic [3:0]  mem_mask;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_in;
  logic        mem_valid;
  logic [31:0] mem_data_out;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_request  (mem_request),
    .mem_we_re    (mem_we_re),
    .mem_mask     (mem_mask),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_valid    (mem_valid),
    .mem_data_out (mem_data_out),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_ready    (out_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: instructions waiting for downstream, next fetch address, outstanding fetch.
  logic [63:0] q[$];
  logic [31:0] m_fpc = 32'h0;
  logic [31:0] m_ipc = 32'h0;
  bit          m_infl = 1'b0;
  bit          m_known = 1'b0;
  bit          m_zero = 1'b0;
  bit          pend_vld = 1'b0;
  logic [7:0]  pend_addr = 8'h0;

  task automatic step(input bit t_rst, input bit t_redir, input logic [31:0] t_rpc, input bit t_rdy);
    bit exp_req;
    bit pop;
    int occ;
    @(posedge clk);
    #1;
    rst         = t_rst;
    redirect    = t_redir;
    redirect_pc = t_rpc;
    out_ready   = t_rdy;
    if (pend_vld) begin
      mem_valid    = 1'b1;
      mem_data_out = 32'h1000_0000 + {24'h0, pend_addr};
    end else if ($urandom_range(0, 3) == 0) begin
      mem_valid    = 1'b1;
      mem_data_out = $urandom;
    end else begin
      mem_valid    = 1'b0;
      mem_data_out = $urandom;
    end
    @(negedge clk);
    pop     = (q.size() != 0) && t_rdy;
    occ     = q.size() - (pop ? 1 : 0) + (m_infl ? 1 : 0);
    exp_req = !t_rst && !t_redir && (occ < 2);
    check("mem_request", {31'h0, mem_request}, {31'h0, exp_req});
    check("mem_we_re", {31'h0, mem_we_re}, 32'h0);
    check("mem_mask", {28'h0, mem_mask}, 32'hF);
    check("mem_data_in", mem_data_in, 32'h0);
    if (m_known) begin
      check("mem_address", {24'h0, mem_address}, {24'h0, m_fpc[9:2]});
      check("out_valid", {31'h0, out_valid}, {31'h0, q.size() != 0});
      if (q.size() != 0) begin
        check("out_pc", out_pc, q[0][31:0]);
        check("out_instr", out_instr, q[0][63:32]);
        check("instr_of_pc", out_instr, 32'h1000_0000 + {24'h0, out_pc[9:2]});
      end else if (m_zero) begin
        check("out_pc_reset", out_pc, 32'h0);
        check("out_instr_reset", out_instr, 32'h0);
      end
    end
    pend_vld  = mem_request;
    pend_addr = mem_address;
    if (t_rst) begin
      q.delete();
      m_infl  = 1'b0;
      m_ipc   = 32'h0;
      m_fpc   = RESET_PC;
      m_known = 1'b1;
      m_zero  = 1'b1;
    end else if (t_redir) begin
      q.delete();
      m_infl = 1'b0;
      m_fpc  = {t_rpc[31:2], 2'b00};
      m_zero = 1'b0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        m_zero = 1'b0;
      end
      if (mem_valid && m_infl) begin
        q.push_back({mem_data_out, m_ipc});
        m_zero = 1'b0;
      end
      if (exp_req) begin
        m_infl = 1'b1;
        m_ipc  = m_fpc;
        m_fpc  = m_fpc + 32'd4;
      end else if (mem_valid) begin
        m_infl = 1'b0;
      end
    end
  endtask

  initial begin
    int r;
    rst          = 1'b1;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    out_ready    = 1'b1;
    mem_valid    = 1'b0;
    mem_data_out = 32'h0;

    step(1, 0, 32'h0, 1);
    step(1, 0, 32'h0, 1);
    repeat (12) step(0, 0, 32'h0, 1);

    // Stalled downstream fills the buffer, then drains without loss.
    step(1, 0, 32'h0, 1);
    repeat (5) step(0, 0, 32'h0, 0);
    repeat (6) step(0, 0, 32'h0, 1);

    // Redirect to an unaligned target while the buffer is full.
    repeat (5) step(0, 0, 32'h0, 0);
    step(0, 1, 32'h0000_0043, 0);
    repeat (8) step(0, 0, 32'h0, 1);

    // 1 KiB address wrap and full 32-bit PC wrap.
    step(0, 1, 32'h0000_03F8, 1);
    repeat (8) step(0, 0, 32'h0, 1);
    step(0, 1, 32'hFFFF_FFF8, 1);
    repeat (6) step(0, 0, 32'h0, 1);

    // Mid-stream reset pulse with downstream stalling.
    step(0, 0, 32'h0, 0);
    step(1, 0, 32'h0, 1);
    repeat (8) step(0, 0, 32'h0, 1);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      step(r < 1, (r >= 1) && (r < 4), $urandom, $urandom_range(0, 9) < 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
